// File: rtl/load_store_unit_if.sv
// Request/response handshake between the datapath and the load/store unit.
// The requester drives the master side; the load/store unit sits on the slave side.
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, funct3, addr, wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output busy, done, err, rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Sequential byte/halfword/word load/store unit for a word-addressed memory.
// Sub-word stores are done as read-modify-write; bad requests never touch memory.
module load_store_unit #(
    parameter int DEPTH_WORDS = 32
) (
    input  logic                clk,
    input  logic                rst,
    load_store_unit_if.slave    bus,
    output logic [9:0]          mem_a,
    output logic [31:0]         mem_wd,
    output logic                mem_we,
    input  logic [31:0]         mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, MODIFY, RESP} state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    state_t      state, state_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [11:0] r_addr;
    logic [31:0] r_wdata;
    logic        err_flag;
    logic [31:0] old_word;
    logic [31:0] rdata_q;

    logic        req_bad;
    logic        legal_f3;
    logic        misaligned;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merged;

    always_comb begin
        legal_f3   = 1'b0;
        misaligned = 1'b0;
        if (bus.we)
            legal_f3 = (bus.funct3 inside {3'b000, 3'b001, 3'b010});
        else
            legal_f3 = (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        if (bus.funct3[1:0] == 2'b01)
            misaligned = bus.addr[0];
        else if (bus.funct3[1:0] == 2'b10)
            misaligned = (bus.addr[1:0] != 2'b00);
        req_bad = !legal_f3 || misaligned || (bus.addr >= ADDR_LIMIT);
    end

    // Lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin
        byte_lane = mem_rd[{r_addr[1:0], 3'b000} +: 8];
        half_lane = r_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (r_funct3)
            3'b000:  load_val = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_val = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_val = {24'd0, byte_lane};
            3'b101:  load_val = {16'd0, half_lane};
            default: load_val = mem_rd;
        endcase
        merged = old_word;
        if (r_funct3[1:0] == 2'b00)
            merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else if (r_addr[1])
            merged[31:16] = r_wdata[15:0];
        else
            merged[15:0] = r_wdata[15:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req) state_next = req_bad ? RESP : ACCESS;
            ACCESS:  state_next = (r_we && r_funct3[1:0] != 2'b10) ? MODIFY : RESP;
            MODIFY:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 12'd0;
            r_wdata  <= 32'd0;
            err_flag <= 1'b0;
            old_word <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        r_we     <= bus.we;
                        r_funct3 <= bus.funct3;
                        r_addr   <= bus.addr[11:0];
                        r_wdata  <= bus.wdata;
                        err_flag <= req_bad;
                    end
                end
                ACCESS: begin
                    if (r_we)
                        old_word <= mem_rd;
                    else
                        rdata_q <= load_val;
                end
                default: ;
            endcase
        end
    end

    // Memory strobes depend only on state and captured registers, so reset kills them at once.
    always_comb begin
        mem_a     = r_addr[11:2];
        mem_wd    = (state == MODIFY) ? merged : r_wdata;
        mem_we    = ((state == ACCESS) && r_we && (r_funct3 == 3'b010)) || (state == MODIFY);
        bus.busy  = (state != IDLE);
        bus.done  = (state == RESP);
        bus.err   = (state == RESP) && err_flag;
        bus.rdata = rdata_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: requests push expected responses,
// a negedge monitor pops them whenever done is presented.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic [9:0]  mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;
    logic [31:0] mem [0:1023];

    load_store_unit_if bus();

    load_store_unit #(.DEPTH_WORDS(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_we (mem_we),
        .mem_rd (mem_rd)
    );

    typedef struct {
        string       name;
        logic        err;
        int          lat;
        logic [31:0] rdata;
        int          issue;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle    = 0;
    int   we_count = 0;
    logic [9:0] we_addr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    assign mem_rd = mem[mem_a];
    always @(posedge clk) if (mem_we) mem[mem_a] <= mem_wd;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Monitor: count memory writes and score every completed request.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && mem_we === 1'b1) begin
            we_count++;
            we_addr = mem_a;
        end
        if (rst === 1'b1 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput({e.name, "_err"}, {31'd0, bus.err}, {31'd0, e.err});
                checkOutput({e.name, "_lat"}, 32'(cycle - e.issue), 32'(e.lat));
                checkOutput({e.name, "_rdata"}, bus.rdata, e.rdata);
            end
        end
    end

    function automatic exp_t make_exp(input string name, input logic e_err, input int e_lat,
                                      input logic [31:0] e_rdata, input int issue);
        exp_t e;
        e.name  = name;
        e.err   = e_err;
        e.lat   = e_lat;
        e.rdata = e_rdata;
        e.issue = issue;
        return e;
    endfunction

    task automatic applyStimulus(input string name, input logic w, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic e_err, input int e_lat, input logic [31:0] e_rdata,
                                 input int e_writes, input logic [9:0] e_wa);
        bit got;
        @(negedge clk);
        we_count   = 0;
        bus.we     = w;
        bus.funct3 = f3;
        bus.addr   = a;
        bus.wdata  = wd;
        bus.req    = 1'b1;
        exp_q.push_back(make_exp(name, e_err, e_lat, e_rdata, cycle));
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            $display("[TB] FAIL %s_timeout: got no done, expected done within 10 cycles", name);
            void'(exp_q.pop_front());
        end
        bus.req = 1'b0;
        @(negedge clk);
        checkOutput({name, "_writes"}, 32'(we_count), 32'(e_writes));
        if (e_writes > 0)
            checkOutput({name, "_we_addr"}, {22'd0, we_addr}, {22'd0, e_wa});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[1] = 32'h1111_1111;
        rst        = 1'b0;
        bus.req    = 1'b0;
        bus.we     = 1'b0;
        bus.funct3 = 3'd0;
        bus.addr   = 32'd0;
        bus.wdata  = 32'd0;
        #1;
        checkOutput("reset_busy",  {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_done",  {31'd0, bus.done}, 32'd0);
        checkOutput("reset_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("reset_rdata", bus.rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        applyStimulus("sw08",  1, 3'b010, 32'h08, 32'hDEADBEEF, 0, 2, 32'h0000_0000, 1, 10'd2);
        checkOutput("mem2_after_sw", mem[2], 32'hDEADBEEF);
        applyStimulus("lw08",  0, 3'b010, 32'h08, 32'h0, 0, 2, 32'hDEADBEEF, 0, 10'd0);
        applyStimulus("lb0b",  0, 3'b000, 32'h0B, 32'h0, 0, 2, 32'hFFFFFFDE, 0, 10'd0);
        applyStimulus("lbu0b", 0, 3'b100, 32'h0B, 32'h0, 0, 2, 32'h000000DE, 0, 10'd0);
        applyStimulus("lh08",  0, 3'b001, 32'h08, 32'h0, 0, 2, 32'hFFFFBEEF, 0, 10'd0);
        applyStimulus("lhu0a", 0, 3'b101, 32'h0A, 32'h0, 0, 2, 32'h0000DEAD, 0, 10'd0);

        applyStimulus("sb09",  1, 3'b000, 32'h09, 32'h12345677, 0, 3, 32'h0000DEAD, 1, 10'd2);
        checkOutput("mem2_after_sb", mem[2], 32'hDEAD77EF);
        applyStimulus("lw_sb", 0, 3'b010, 32'h08, 32'h0, 0, 2, 32'hDEAD77EF, 0, 10'd0);
        applyStimulus("sh0a",  1, 3'b001, 32'h0A, 32'hAAAA1234, 0, 3, 32'hDEAD77EF, 1, 10'd2);
        applyStimulus("lw_sh", 0, 3'b010, 32'h08, 32'h0, 0, 2, 32'h123477EF, 0, 10'd0);

        applyStimulus("err_lw06",  0, 3'b010, 32'h06, 32'h0,        1, 1, 32'h123477EF, 0, 10'd0);
        applyStimulus("err_sh05",  1, 3'b001, 32'h05, 32'hFFFFFFFF, 1, 1, 32'h123477EF, 0, 10'd0);
        applyStimulus("err_sw80",  1, 3'b010, 32'h80, 32'hFFFFFFFF, 1, 1, 32'h123477EF, 0, 10'd0);
        applyStimulus("err_ld011", 0, 3'b011, 32'h08, 32'h0,        1, 1, 32'h123477EF, 0, 10'd0);
        applyStimulus("err_st100", 1, 3'b100, 32'h08, 32'hFFFFFFFF, 1, 1, 32'h123477EF, 0, 10'd0);
        checkOutput("mem2_after_errs", mem[2], 32'h123477EF);
        checkOutput("mem0_after_errs", mem[0], 32'h0000_0000);
        checkOutput("mem1_after_errs", mem[1], 32'h1111_1111);

        // Back-to-back requests with req held high and inputs changing while busy.
        @(negedge clk);
        bus.we = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h08; bus.req = 1'b1;
        exp_q.push_back(make_exp("hold_lw", 0, 2, 32'h123477EF, cycle));
        @(negedge clk);
        checkOutput("hold_busy_access", {31'd0, bus.busy}, 32'd1);
        bus.we = 1'b1; bus.addr = 32'h04; bus.wdata = 32'hCAFEF00D;
        #1;
        checkOutput("hold_mem_a_stable", {22'd0, mem_a}, 32'd2);
        checkOutput("hold_lw_no_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        checkOutput("hold_mem_a_resp", {22'd0, mem_a}, 32'd2);
        @(negedge clk);
        checkOutput("hold_idle_gap", {31'd0, bus.busy}, 32'd0);
        exp_q.push_back(make_exp("hold_sw", 0, 2, 32'h123477EF, cycle));
        @(negedge clk);
        checkOutput("hold_sw_we", {31'd0, mem_we}, 32'd1);
        checkOutput("hold_sw_mem_a", {22'd0, mem_a}, 32'd1);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        checkOutput("mem1_after_hold_sw", mem[1], 32'hCAFEF00D);

        // Reset in the middle of a read-modify-write.
        @(negedge clk);
        bus.we = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h08; bus.wdata = 32'h55; bus.req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rmw_we_before_reset", {31'd0, mem_we}, 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("rmw_we_after_reset", {31'd0, mem_we}, 32'd0);
        checkOutput("rmw_busy_reset",  {31'd0, bus.busy}, 32'd0);
        checkOutput("rmw_done_reset",  {30'd0, bus.done, bus.err}, 32'd0);
        checkOutput("rmw_rdata_reset", bus.rdata, 32'd0);
        checkOutput("rmw_mem_a_reset", {22'd0, mem_a}, 32'd0);
        checkOutput("rmw_mem_wd_reset", mem_wd, 32'd0);
        bus.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        checkOutput("mem2_after_rmw_reset", mem[2], 32'h123477EF);
        applyStimulus("lw_after_reset", 0, 3'b010, 32'h08, 32'h0, 0, 2, 32'h123477EF, 0, 10'd0);

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store unit between the processor datapath and the word-addressed data memory (`Data_mem`). It accepts one byte, halfword or word request at a time. Loads are sign- or zero-extended. Sub-word stores use read-modify-write, because the memory only writes whole 32-bit words. Misaligned, out-of-range and illegal requests are rejected without touching memory.

## Interface
Parameters:
- `DEPTH_WORDS`, default 32: number of memory words. Legal byte addresses are 0 .. 4*DEPTH_WORDS-1.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `req`  in  1: request strobe; sampled only in IDLE.
- `we`  in  1: 1 = store, 0 = load.
- `funct3`  in  3: access type.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `addr`  in  32: byte address.
- `wdata`  in  32: store data; the byte or halfword is taken from its low bits.
- `busy`  out  1: 1 whenever state is not IDLE.
- `done`  out  1: one-cycle pulse when a request completes.
- `err`  out  1: valid with `done`; 1 = request rejected.
- `rdata`  out  32: load result; valid with `done` for loads and held until the next `done`.
- `mem_a`  out  10: memory word address, equal to captured `addr[11:2]`.
- `mem_wd`  out  32: memory write data.
- `mem_we`  out  1: memory write enable.
- `mem_rd`  in  32: memory read data (combinational from `mem_a`).

## Operation
- States: IDLE, ACCESS, MODIFY, RESP.
- IDLE with `req`=1:
  - Capture `we`, `funct3`, `addr` and `wdata` into request registers.
  - Check the request:
    - illegal: `funct3` not in the list for the direction;
    - misaligned: halfword with `addr[0]`≠0, or word with `addr[1:0]`≠0;
    - out of range: `addr` ≥ 4*DEPTH_WORDS.
  - Any check fails: go to RESP with the error flag set.
  - Otherwise: go to ACCESS.
- ACCESS:
  - Load: register `mem_rd`, extract the lane selected by `addr[1:0]`, extend it, go to RESP.
  - SW: `mem_we`=1, `mem_wd`=captured `wdata`, go to RESP.
  - SB/SH: register `mem_rd` as the old word, go to MODIFY.
- MODIFY:
  - `mem_we`=1.
  - `mem_wd` = old word with the target byte or halfword lane replaced by `wdata[7:0]` or `wdata[15:0]`; other lanes unchanged.
  - Go to RESP.
- RESP: `done`=1, `err` = error flag, return to IDLE.
- Lane rules:
  - Byte lane k = bits [8k+7:8k], k = `addr[1:0]`.
  - Halfword lane = bits [15:0] when `addr[1]`=0, [31:16] when `addr[1]`=1.
  - LB and LH sign-extend from the top bit of the lane; LBU and LHU zero-fill.
- `req` while `busy`=1 is ignored and not queued. The requester holds `req` until it sees `done`, then deasserts it; `req` still high in the IDLE cycle after RESP starts a new request.
- `mem_we` is asserted only in ACCESS (SW) or MODIFY (SB/SH) of a legal store. It is never asserted for loads or rejected requests.
- A store completing with `err`=1 leaves memory unmodified. On an error, `rdata` keeps its previous value.
- `mem_a` and `mem_wd` come only from the captured request registers, so they stay stable while `busy`=1 even if inputs change.

## Timing
- Request accepted on edge E0, i.e. `req`=1 sampled in IDLE.
- LW/LB/LH/LBU/LHU and SW: ACCESS during cycle E0..E1; `done` is high in cycle E1..E2 (RESP). The memory write for SW commits at E1.
- SB/SH: ACCESS during E0..E1, MODIFY during E1..E2 with the write committing at E2, `done` during E2..E3.
- Rejected request: `done`=1, `err`=1 during cycle E0..E1.
- Next request can be accepted at the edge ending RESP+1, i.e. one IDLE cycle between requests.
- `rst` low, at any time including mid-operation:
  - State goes to IDLE immediately.
  - `busy`, `done`, `err` and `mem_we` = 0; `rdata`, `mem_a` and `mem_wd` = 0; all request registers clear.
  - `mem_we` drops asynchronously, so an interrupted RMW writes nothing.
  - The first request can be accepted on the first rising edge with `rst`=1.

## Test plan
- Reset, then SW `addr`=0x08, `wdata`=0xDEADBEEF:
  - `mem_we` is high for exactly 1 cycle with `mem_a`=2;
  - `done` arrives 2 cycles after `req`, `err`=0;
  - a following LW 0x08 returns `rdata`=0xDEADBEEF.
- Word 2 = 0xDEADBEEF:
  - LB 0x0B → 0xFFFFFFDE; LBU 0x0B → 0x000000DE;
  - LH 0x08 → 0xFFFFBEEF; LHU 0x0A → 0x0000DEAD.
- Word 2 = 0xDEADBEEF:
  - SB 0x09 with `wdata`=0x12345677: `done` at 3 cycles, then word 2 = 0xDEAD77EF;
  - SH 0x0A with `wdata`=0xAAAA1234: word 2 = 0x123477EF.
- Error cases (each must give `done`=1, `err`=1 one cycle after `req`, `mem_we` never asserted, memory unchanged):
  - LW 0x06 (misaligned);
  - SH 0x05 (misaligned);
  - SW 0x80 with DEPTH_WORDS=32 (out of range);
  - load with `funct3`=011 (illegal).
- Hold `req`=1 continuously for a LW then a SW:
  - the second request is accepted only after RESP plus one IDLE cycle;
  - `addr` changes while `busy` do not affect `mem_a`.
- Start SB, pull `rst` low during MODIFY:
  - `mem_we` falls immediately and the target word is unchanged;
  - all outputs are 0;
  - after release, a LW of the same word returns the original value.
